// File: rtl/onchip_mem_pkg.sv
// Shared types and helpers for the dual-port on-chip memory.
// The optional parity feature is selected with ONCHIP_MEM_PARITY_EN.
package onchip_mem_pkg;

  // Clear engine states. IDLE is a one-cycle handoff between CLEAR and READY.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } clr_state_e;

  // Number of byte lanes in a data word.
  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  // Even parity bit for one byte: byte ^ parity has an even number of ones.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/onchip_mem_rd_pipe.sv
// Per-port read-valid/data pipeline, READ_LATENCY (1 or 2) enabled cycles deep.
// All stages hold while clken is low; valid is masked while held so a
// pending read is presented exactly once.
module onchip_mem_rd_pipe #(
  parameter int W            = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clken,
  input  logic         i_accept,
  input  logic         i_zero,
  input  logic [W-1:0] i_ram_q,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_v1;
  logic         r_zero;
  logic         r_seen;
  logic [W-1:0] w_s1_data;

  // First stage: tracks the read issued to the RAM and whether it must return zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1   <= 1'b0;
      r_zero <= 1'b0;
      r_seen <= 1'b0;
    end else if (clken) begin
      r_v1 <= i_accept;
      if (i_accept) begin
        r_zero <= i_zero;
        r_seen <= 1'b1;
      end
    end
  end

  // The RAM output register only loads on accepted reads, so it already holds.
  assign w_s1_data = (r_seen && !r_zero) ? i_ram_q : '0;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign o_valid = r_v1 & clken;
      assign o_data  = w_s1_data;
    end else begin : g_lat2
      logic         r_v2;
      logic [W-1:0] r_data2;

      // Extra output register stage; data only loads when a read moves through.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_v2    <= 1'b0;
          r_data2 <= '0;
        end else if (clken) begin
          r_v2 <= r_v1;
          if (r_v1) r_data2 <= w_s1_data;
        end
      end

      assign o_valid = r_v2 & clken;
      assign o_data  = r_data2;
    end
  endgenerate

endmodule

// File: rtl/onchip_mem_dp.sv
// True-dual-port Avalon-MM on-chip RAM with byte enables, selectable read
// latency and an optional clear-after-reset engine. Define
// ONCHIP_MEM_PARITY_EN to add per-lane even parity and error outputs.
// Port s1 owns RAM port A, which the clear engine also uses.
module onchip_mem_dp
  import onchip_mem_pkg::*;
#(
  parameter int    DATA_W         = 32,
  parameter int    ADDR_W         = 13,
  parameter int    DEPTH          = 7680,
  parameter int    READ_LATENCY   = 1,
  parameter int    CLEAR_ON_RESET = 0,
  parameter string INIT_FILE      = "onchip_mem.hex"
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  output logic                  busy,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic                  s1_chipselect,
  input  logic                  s1_write,
  input  logic                  s1_read,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  output logic                  s1_waitrequest,
  input  logic [ADDR_W-1:0]     s2_address,
  input  logic [DATA_W/8-1:0]   s2_byteenable,
  input  logic                  s2_chipselect,
  input  logic                  s2_write,
  input  logic                  s2_read,
  input  logic [DATA_W-1:0]     s2_writedata,
  output logic [DATA_W-1:0]     s2_readdata,
  output logic                  s2_readdatavalid,
  output logic                  s2_waitrequest
`ifdef ONCHIP_MEM_PARITY_EN
  ,
  output logic                  s1_parity_err,
  output logic                  s2_parity_err,
  output logic                  parity_err_sticky
`endif
);

  // INIT_FILE is carried for the vendor memory-initialisation flow.
  localparam int NB    = lane_count(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef ONCHIP_MEM_PARITY_EN
  localparam int PW    = DATA_W + NB;
`else
  localparam int PW    = DATA_W;
`endif

  clr_state_e        r_state;
  clr_state_e        w_state_next;
  logic [IDX_W-1:0]  r_clr_addr;
  logic [IDX_W-1:0]  w_clr_addr_next;
  logic              w_clr_we;
  logic              w_wait;
  logic              w_s1_inr, w_s2_inr;
  logic              w_s1_wr, w_s1_rd, w_s2_wr, w_s2_rd;
  logic              w_s1_we, w_s1_re, w_s2_we, w_s2_re;
  logic [IDX_W-1:0]  w_s1_idx, w_s2_idx;
  logic [DATA_W-1:0] w_s1_data_q, w_s2_data_q;
  logic [PW-1:0]     w_s1_ram_q, w_s2_ram_q;
  logic [PW-1:0]     w_s1_pipe_data, w_s2_pipe_data;
  logic              w_s1_valid, w_s2_valid;

  // Clear engine state register; advances only on enabled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      r_clr_addr <= '0;
    end else if (clken) begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
    end
  end

  // Clear engine next state: sweep 0..DEPTH-1, then a one-cycle IDLE handoff.
  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    w_clr_we        = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_addr == IDX_W'(DEPTH - 1)) begin
          w_state_next    = IDLE;
          w_clr_addr_next = '0;
        end else begin
          w_clr_addr_next = r_clr_addr + 1'b1;
        end
      end
      IDLE:    w_state_next = READY;
      READY:   w_state_next = READY;
      default: w_state_next = READY;
    endcase
  end

  assign busy   = (r_state == CLEAR);
  assign w_wait = (r_state != READY) | ~clken | ~reset_n;
  assign s1_waitrequest = w_wait;
  assign s2_waitrequest = w_wait;

  // Request decode; a simultaneous read and write on one port is a write.
  assign w_s1_inr = {1'b0, s1_address} < (ADDR_W + 1)'(DEPTH);
  assign w_s2_inr = {1'b0, s2_address} < (ADDR_W + 1)'(DEPTH);
  assign w_s1_wr  = s1_chipselect & ~w_wait & s1_write;
  assign w_s1_rd  = s1_chipselect & ~w_wait & s1_read & ~s1_write;
  assign w_s2_wr  = s2_chipselect & ~w_wait & s2_write;
  assign w_s2_rd  = s2_chipselect & ~w_wait & s2_read & ~s2_write;
  assign w_s1_we  = w_s1_wr & w_s1_inr;
  assign w_s1_re  = w_s1_rd & w_s1_inr;
  assign w_s2_we  = w_s2_wr & w_s2_inr;
  assign w_s2_re  = w_s2_rd & w_s2_inr;
  assign w_s1_idx = s1_address[IDX_W-1:0];
  assign w_s2_idx = s2_address[IDX_W-1:0];

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_q1, r_q2;

      // Byte-lane RAM: s2 is written first so s1 wins an overlapping lane;
      // reads use the pre-edge contents, giving old data on a collision.
      always_ff @(posedge clk) begin
        if (clken) begin
          if (w_s2_we && s2_byteenable[gi]) r_mem[w_s2_idx] <= s2_writedata[gi*8 +: 8];
          if (w_clr_we) r_mem[r_clr_addr] <= 8'h00;
          else if (w_s1_we && s1_byteenable[gi]) r_mem[w_s1_idx] <= s1_writedata[gi*8 +: 8];
          if (w_s1_re) r_q1 <= r_mem[w_s1_idx];
          if (w_s2_re) r_q2 <= r_mem[w_s2_idx];
        end
      end

      assign w_s1_data_q[gi*8 +: 8] = r_q1;
      assign w_s2_data_q[gi*8 +: 8] = r_q2;
    end
  endgenerate

`ifdef ONCHIP_MEM_PARITY_EN
  logic [NB-1:0] w_s1_par_q, w_s2_par_q;
  logic          w_s1_perr, w_s2_perr;
  logic          r_par_sticky;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_par
      logic r_par [DEPTH];
      logic r_pq1, r_pq2;

      // Parity bit per lane, written alongside the lane data.
      always_ff @(posedge clk) begin
        if (clken) begin
          if (w_s2_we && s2_byteenable[gi]) r_par[w_s2_idx] <= even_parity(s2_writedata[gi*8 +: 8]);
          if (w_clr_we) r_par[r_clr_addr] <= 1'b0;
          else if (w_s1_we && s1_byteenable[gi]) r_par[w_s1_idx] <= even_parity(s1_writedata[gi*8 +: 8]);
          if (w_s1_re) r_pq1 <= r_par[w_s1_idx];
          if (w_s2_re) r_pq2 <= r_par[w_s2_idx];
        end
      end

      assign w_s1_par_q[gi] = r_pq1;
      assign w_s2_par_q[gi] = r_pq2;
    end
  endgenerate

  assign w_s1_ram_q = {w_s1_par_q, w_s1_data_q};
  assign w_s2_ram_q = {w_s2_par_q, w_s2_data_q};

  // Parity check on the pipeline output so the flag lines up with valid.
  always_comb begin
    w_s1_perr = 1'b0;
    w_s2_perr = 1'b0;
    for (int l = 0; l < NB; l++) begin
      w_s1_perr = w_s1_perr | (even_parity(w_s1_pipe_data[l*8 +: 8]) ^ w_s1_pipe_data[DATA_W+l]);
      w_s2_perr = w_s2_perr | (even_parity(w_s2_pipe_data[l*8 +: 8]) ^ w_s2_pipe_data[DATA_W+l]);
    end
  end

  assign s1_parity_err = w_s1_valid & w_s1_perr;
  assign s2_parity_err = w_s2_valid & w_s2_perr;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_par_sticky <= 1'b0;
    else if (s1_parity_err || s2_parity_err) r_par_sticky <= 1'b1;
  end

  assign parity_err_sticky = r_par_sticky;
`else
  assign w_s1_ram_q = w_s1_data_q;
  assign w_s2_ram_q = w_s2_data_q;
`endif

  onchip_mem_rd_pipe #(.W(PW), .READ_LATENCY(READ_LATENCY)) u_rd_pipe_s1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .clken    (clken),
    .i_accept (w_s1_rd),
    .i_zero   (~w_s1_inr),
    .i_ram_q  (w_s1_ram_q),
    .o_valid  (w_s1_valid),
    .o_data   (w_s1_pipe_data)
  );

  onchip_mem_rd_pipe #(.W(PW), .READ_LATENCY(READ_LATENCY)) u_rd_pipe_s2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .clken    (clken),
    .i_accept (w_s2_rd),
    .i_zero   (~w_s2_inr),
    .i_ram_q  (w_s2_ram_q),
    .o_valid  (w_s2_valid),
    .o_data   (w_s2_pipe_data)
  );

  assign s1_readdatavalid = w_s1_valid;
  assign s2_readdatavalid = w_s2_valid;
  assign s1_readdata      = w_s1_pipe_data[DATA_W-1:0];
  assign s2_readdata      = w_s2_pipe_data[DATA_W-1:0];

endmodule
